// File: rtl/tvc_dl_writer.sv
// tvc_dl_writer: packs the data_io download byte stream into 16-bit SDRAM word
// writes through a small word FIFO. It throttles data_io via dn_clkref and
// publishes rom_loaded / cart_valid / cas_len when a download completes.
//
// Optional feature macro: TVC_DL_CSUM_EN. When it is defined, csum is the
// 16-bit wrapping sum of the accepted bytes of the last download. When it is
// undefined, csum is tied to zero.
//
// Ports
//   clk_sys, res_n          clock, asynchronous active-low reset
//   dn_go/dn_wr/dn_addr/    download handshake from data_io
//   dn_data/dn_idx
//   dn_clkref               1 = next byte can be accepted
//   cart_unload             level, clears cart_valid
//   mem_req/mem_ack/        word write port (req held until ack)
//   mem_addr/mem_wdata/
//   mem_be
//   busy, overflow          status (overflow sticky until next download)
//   rom_loaded, cart_valid, completion flags
//   cas_len, csum
`timescale 1ns/1ps

module tvc_dl_writer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [22:0] CART_BASE  = 23'h040000,
    parameter logic [22:0] CAS_BASE   = 23'h080000
) (
    input  logic        clk_sys,
    input  logic        res_n,
    input  logic        dn_go,
    input  logic        dn_wr,
    input  logic [24:0] dn_addr,
    input  logic [7:0]  dn_data,
    input  logic [5:0]  dn_idx,
    output logic        dn_clkref,
    input  logic        cart_unload,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [22:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_be,
    output logic        busy,
    output logic        overflow,
    output logic        rom_loaded,
    output logic        cart_valid,
    output logic [24:0] cas_len,
    output logic [15:0] csum
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

    typedef struct packed {
        logic [22:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } word_t;

    state_t         state;
    state_t         state_nx;
    logic           go_q;
    logic           go_rise;
    logic [5:0]     idx_q;
    logic           pend_q;
    logic [7:0]     lo_q;
    logic [23:0]    paddr_q;
    logic [25:0]    max_p1_q;

    word_t          fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  rd_ptr_nx;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_nx;
    logic [CW-1:0]  avail;

    logic           pop;
    logic           push;
    word_t          push_word;
    word_t          lo_word;
    word_t          head;
    logic           pend_nx;
    logic [7:0]     lo_nx;
    logic [23:0]    paddr_nx;
    logic           accept;
    logic           drop;
    logic [22:0]    base;
    logic [22:0]    byte_waddr;
    logic [25:0]    addr_p1;
    logic           busy_nx;
    logic           clkref_nx;

    assign go_rise    = dn_go & ~go_q;
    assign pop        = mem_req & mem_ack;
    // Slots usable this cycle: a word leaving on ack frees its slot for a same-cycle push.
    assign avail      = CW'(FIFO_DEPTH) - count + CW'(pop);
    assign base       = (idx_q == 6'd0) ? 23'h0 : ((idx_q == 6'd1) ? CART_BASE : CAS_BASE);
    assign byte_waddr = base + dn_addr[23:1];
    assign addr_p1    = {1'b0, dn_addr} + 26'd1;
    assign lo_word    = '{addr: base + paddr_q[22:0], data: {8'h00, lo_q}, be: 2'b01};

    // State register
    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (go_rise) state_nx = S_LOAD;
            S_LOAD:  if (!dn_go) state_nx = S_FLUSH;
            S_FLUSH: if ((count == '0) && !mem_req && !pend_q) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Output logic (values registered below)
    always_comb begin
        busy_nx   = (state_nx != S_IDLE);
        clkref_nx = 1'b0;
        case (state_nx)
            S_IDLE:  clkref_nx = 1'b1;
            S_LOAD:  clkref_nx = ((CW'(FIFO_DEPTH) - count_nx) >= CW'(2));
            default: clkref_nx = 1'b0;
        endcase
    end

    // Byte packing: decides push, pending-byte update, accept/drop
    always_comb begin
        push      = 1'b0;
        push_word = '0;
        pend_nx   = pend_q;
        lo_nx     = lo_q;
        paddr_nx  = paddr_q;
        accept    = 1'b0;
        drop      = 1'b0;
        if (state == S_IDLE) begin
            if (go_rise) pend_nx = 1'b0;
        end else if ((state == S_LOAD) && dn_wr) begin
            if (!dn_addr[0]) begin
                if (!pend_q) begin
                    pend_nx  = 1'b1;
                    lo_nx    = dn_data;
                    paddr_nx = dn_addr[24:1];
                    accept   = 1'b1;
                end else if (avail >= CW'(2)) begin
                    push      = 1'b1;
                    push_word = lo_word;
                    lo_nx     = dn_data;
                    paddr_nx  = dn_addr[24:1];
                    accept    = 1'b1;
                end else if (avail != '0) begin
                    // Old even byte still goes out; the new one has no guaranteed room.
                    push      = 1'b1;
                    push_word = lo_word;
                    pend_nx   = 1'b0;
                    drop      = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end else if (pend_q && (dn_addr[24:1] == paddr_q)) begin
                if (avail != '0) begin
                    push      = 1'b1;
                    push_word = '{addr: lo_word.addr, data: {dn_data, lo_q}, be: 2'b11};
                    pend_nx   = 1'b0;
                    accept    = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end else begin
                if (avail != '0) begin
                    push      = 1'b1;
                    push_word = '{addr: byte_waddr, data: {dn_data, 8'h00}, be: 2'b10};
                    accept    = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
        end else if ((state == S_FLUSH) && pend_q && (avail != '0)) begin
            push      = 1'b1;
            push_word = lo_word;
            pend_nx   = 1'b0;
        end
    end

    // Post-update FIFO head; bypasses the pushed word when the FIFO would be empty
    always_comb begin
        rd_ptr_nx = rd_ptr + AW'(pop);
        count_nx  = count - CW'(pop) + CW'(push);
        head      = fifo_mem[rd_ptr_nx];
        if ((count - CW'(pop)) == '0) head = push_word;
    end

    // FIFO storage
    always_ff @(posedge clk_sys) begin
        if (push) fifo_mem[wr_ptr] <= push_word;
    end

    // Datapath, memory port and status registers
    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            go_q       <= 1'b0;
            idx_q      <= '0;
            pend_q     <= 1'b0;
            lo_q       <= '0;
            paddr_q    <= '0;
            max_p1_q   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            dn_clkref  <= 1'b1;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            rom_loaded <= 1'b0;
            cart_valid <= 1'b0;
            cas_len    <= '0;
        end else begin
            go_q      <= dn_go;
            pend_q    <= pend_nx;
            lo_q      <= lo_nx;
            paddr_q   <= paddr_nx;
            rd_ptr    <= rd_ptr_nx;
            count     <= count_nx;
            busy      <= busy_nx;
            dn_clkref <= clkref_nx;
            if (push) wr_ptr <= wr_ptr + AW'(1);

            mem_req <= (count_nx != '0);
            if (count_nx != '0) begin
                mem_addr  <= head.addr;
                mem_wdata <= head.data;
                mem_be    <= head.be;
            end

            if ((state == S_IDLE) && go_rise) begin
                idx_q    <= dn_idx;
                overflow <= 1'b0;
                max_p1_q <= '0;
            end else begin
                if (drop) overflow <= 1'b1;
                if (accept && (addr_p1 > max_p1_q)) max_p1_q <= addr_p1;
            end

            if ((state == S_DONE) && (idx_q == 6'd0)) rom_loaded <= 1'b1;
            if ((state == S_DONE) && (idx_q >= 6'd2)) cas_len <= max_p1_q[24:0];
            // Completion of a cartridge download wins over a concurrent unload.
            if ((state == S_DONE) && (idx_q == 6'd1)) cart_valid <= 1'b1;
            else if (cart_unload)                     cart_valid <= 1'b0;
        end
    end

`ifdef TVC_DL_CSUM_EN
    // Running byte sum of the current download
    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n)                         csum <= '0;
        else if ((state == S_IDLE) && go_rise) csum <= '0;
        else if (accept)                    csum <= csum + {8'h00, dn_data};
    end
`else
    assign csum = 16'h0000;
`endif

endmodule
